// File: rtl/id_stage_fwd.sv
// id_stage_fwd: decode stage with its own IF/ID register, LA32R-subset
// decoder, branch resolution and operand bypass from NUM_FWD later stages.
// Build option: define ID_FWD_EN to bypass results from the fwd_* sources;
// left undefined, any register match against a fwd source stalls instead.
module id_stage_fwd #(
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned ALU_OP_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [31:0]           if_inst,
    input  logic [31:0]           if_pc,
    output logic                  id_allow_in,
    input  logic                  ex_allow_in,
    output logic                  id_valid,
    output logic [ALU_OP_W-1:0]   id_alu_op,
    output logic [31:0]           id_src1,
    output logic [31:0]           id_src2,
    output logic [31:0]           id_rkd,
    output logic                  id_mem_en,
    output logic [3:0]            id_mem_we,
    output logic                  id_res_from_mem,
    output logic                  id_rf_we,
    output logic [4:0]            id_rf_waddr,
    output logic [31:0]           id_pc,
    output logic [4:0]            rf_raddr1,
    output logic [4:0]            rf_raddr2,
    input  logic [31:0]           rf_rdata1,
    input  logic [31:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]    fwd_we,
    input  logic [5*NUM_FWD-1:0]  fwd_addr,
    input  logic [32*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]    fwd_pend,
    output logic                  br_taken,
    output logic [31:0]           br_target
);

    // pipeline register contents
    logic        id_vld;
    logic [31:0] inst_r;
    logic [31:0] pc_r;

    // id_vld is masked by reset so outputs are quiet before the first edge
    logic vld;
    assign vld = id_vld & reset;

    // instruction fields
    logic [4:0]  f_rd, f_rj, f_rk;
    logic [11:0] f_si12;
    logic [19:0] f_si20;
    logic [15:0] f_offs16;
    logic [25:0] f_offs26;

    assign f_rd     = inst_r[4:0];
    assign f_rj     = inst_r[9:5];
    assign f_rk     = inst_r[14:10];
    assign f_si12   = inst_r[21:10];
    assign f_si20   = inst_r[24:5];
    assign f_offs16 = inst_r[25:10];
    assign f_offs26 = {inst_r[9:0], inst_r[25:10]};

    // opcode match
    logic is_add, is_sub, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
    logic is_slli, is_srli, is_srai, is_addi, is_ld, is_st, is_lui;
    logic is_jirl, is_b, is_bl, is_beq, is_bne;

    assign is_add  = inst_r[31:15] == 17'h00020;
    assign is_sub  = inst_r[31:15] == 17'h00022;
    assign is_slt  = inst_r[31:15] == 17'h00024;
    assign is_sltu = inst_r[31:15] == 17'h00025;
    assign is_nor  = inst_r[31:15] == 17'h00028;
    assign is_and  = inst_r[31:15] == 17'h00029;
    assign is_or   = inst_r[31:15] == 17'h0002a;
    assign is_xor  = inst_r[31:15] == 17'h0002b;
    assign is_slli = inst_r[31:15] == 17'h00081;
    assign is_srli = inst_r[31:15] == 17'h00089;
    assign is_srai = inst_r[31:15] == 17'h00091;
    assign is_addi = inst_r[31:22] == 10'b0000001010;
    assign is_ld   = inst_r[31:22] == 10'b0010100010;
    assign is_st   = inst_r[31:22] == 10'b0010100110;
    assign is_lui  = inst_r[31:25] == 7'b0001010;
    assign is_jirl = inst_r[31:26] == 6'b010011;
    assign is_b    = inst_r[31:26] == 6'b010100;
    assign is_bl   = inst_r[31:26] == 6'b010101;
    assign is_beq  = inst_r[31:26] == 6'b010110;
    assign is_bne  = inst_r[31:26] == 6'b010111;

    // control decode
    logic        is_3r, is_shift;
    logic        use_rj, use_src2, src2_is_rd;
    logic        gr_we, sel_pc, sel_4, sel_imm;
    logic [4:0]  dest;
    logic [31:0] imm, br_offs;
    logic [11:0] op_vec;

    // derive control signals and immediates from the held instruction
    always_comb begin
        is_3r      = is_add | is_sub | is_slt | is_sltu | is_nor | is_and | is_or | is_xor;
        is_shift   = is_slli | is_srli | is_srai;
        src2_is_rd = is_st | is_beq | is_bne;
        use_rj     = is_3r | is_shift | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
        use_src2   = is_3r | src2_is_rd;
        gr_we      = is_3r | is_shift | is_addi | is_ld | is_lui | is_jirl | is_bl;
        dest       = is_bl ? 5'd1 : f_rd;
        sel_pc     = is_bl | is_jirl;
        sel_4      = is_bl | is_jirl;
        sel_imm    = is_shift | is_addi | is_ld | is_st | is_lui;

        imm = '0;
        if (is_shift)
            imm = {27'b0, f_rk};
        else if (is_lui)
            imm = {f_si20, 12'b0};
        else
            imm = {{20{f_si12[11]}}, f_si12};

        if (is_b | is_bl)
            br_offs = {{4{f_offs26[25]}}, f_offs26, 2'b00};
        else
            br_offs = {{14{f_offs16[15]}}, f_offs16, 2'b00};

        op_vec     = '0;
        op_vec[0]  = is_add | is_addi | is_ld | is_st | is_jirl | is_bl;
        op_vec[1]  = is_sub;
        op_vec[2]  = is_slt;
        op_vec[3]  = is_sltu;
        op_vec[4]  = is_and;
        op_vec[5]  = is_nor;
        op_vec[6]  = is_or;
        op_vec[7]  = is_xor;
        op_vec[8]  = is_slli;
        op_vec[9]  = is_srli;
        op_vec[10] = is_srai;
        op_vec[11] = is_lui;
    end

    assign rf_raddr1 = f_rj;
    assign rf_raddr2 = src2_is_rd ? f_rd : f_rk;

    // bypass lookup: lowest-index matching source wins
    logic        hit1, hit2;
    logic        blk1, blk2;
    logic [31:0] rj_val, op2_val;

`ifdef ID_FWD_EN
    logic        pend1, pend2;
    logic [31:0] fdat1, fdat2;

    // find the youngest producer of each source register
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        fdat1 = '0;
        fdat2 = '0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit1 && fwd_we[i] && fwd_addr[i*5 +: 5] == rf_raddr1 && rf_raddr1 != 5'd0) begin
                hit1  = 1'b1;
                pend1 = fwd_pend[i];
                fdat1 = fwd_data[i*32 +: 32];
            end
            if (!hit2 && fwd_we[i] && fwd_addr[i*5 +: 5] == rf_raddr2 && rf_raddr2 != 5'd0) begin
                hit2  = 1'b1;
                pend2 = fwd_pend[i];
                fdat2 = fwd_data[i*32 +: 32];
            end
        end
        blk1    = hit1 & pend1;
        blk2    = hit2 & pend2;
        rj_val  = hit1 ? fdat1 : rf_rdata1;
        op2_val = hit2 ? fdat2 : rf_rdata2;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data, fwd_pend};

    // without bypass, any in-flight producer of a source stalls the consumer
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (fwd_we[i] && fwd_addr[i*5 +: 5] == rf_raddr1 && rf_raddr1 != 5'd0)
                hit1 = 1'b1;
            if (fwd_we[i] && fwd_addr[i*5 +: 5] == rf_raddr2 && rf_raddr2 != 5'd0)
                hit2 = 1'b1;
        end
        blk1    = hit1;
        blk2    = hit2;
        rj_val  = rf_rdata1;
        op2_val = rf_rdata2;
    end
`endif

    // handshake and branch resolution
    logic stall, ready_go, eq, cond;

    assign stall       = vld & ((use_rj & blk1) | (use_src2 & blk2));
    assign ready_go    = ~stall;
    assign id_allow_in = ~vld | (ready_go & ex_allow_in);
    assign id_valid    = vld & ready_go;

    assign eq        = rj_val == op2_val;
    assign cond      = (is_beq & eq) | (is_bne & ~eq) | is_b | is_bl | is_jirl;
    assign br_taken  = vld & ready_go & ex_allow_in & cond;
    assign br_target = (is_jirl ? rj_val : pc_r) + br_offs;

    // datapath outputs
    assign id_alu_op       = ALU_OP_W'(op_vec);
    assign id_src1         = sel_pc ? pc_r : rj_val;
    assign id_src2         = sel_4 ? 32'd4 : (sel_imm ? imm : op2_val);
    assign id_rkd          = op2_val;
    assign id_mem_en       = is_ld | is_st;
    assign id_mem_we       = is_st ? 4'hf : 4'h0;
    assign id_res_from_mem = is_ld;
    assign id_rf_we        = gr_we & vld & (dest != 5'd0);
    assign id_rf_waddr     = dest;
    assign id_pc           = pc_r;

    // IF/ID register: load on accept, drop the wrong-path fetch on redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_vld <= 1'b0;
            inst_r <= '0;
            pc_r   <= '0;
        end else if (id_allow_in) begin
            id_vld <= if_valid & ~br_taken;
            inst_r <= if_inst;
            pc_r   <= if_pc;
        end
    end

endmodule
